// File: rtl/phy_rx_pkg.sv
// Shared lane-receiver definitions: comma symbol, FSM encoding and lock default.
// Also used by phy_tx, which sends COMMA_SYMBOL on its serial output while its valid is low.
package phy_rx_pkg;

    localparam logic [7:0] COMMA_SYMBOL     = 8'hBC;
    localparam int         LOCK_COUNT_DEF   = 4;
    localparam int         MAX_DATA_RUN_DEF = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/serial_paralelo_rx_deser_shift.sv
// MSB-first deserializer; window_o is the byte completed by the bit currently on serial_in.
module deser_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] window_o
);

    logic [WIDTH-1:0] sh_q;

    assign window_o = {sh_q[WIDTH-2:0], serial_in};

    always_ff @(posedge clk_8f) begin
        if (reset) sh_q <= '0;
        else       sh_q <= window_o;
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Lane receiver: comma-aligned deserializer with lock detection and byte delivery.
// Optional SERIAL_PARALELO_RX_LOSS_EN drops lock after MAX_DATA_RUN consecutive non-comma bytes.
//
//   state  | meaning
//   HUNT   | sliding search for a comma at any bit offset
//   ALIGN  | boundary fixed, counting consecutive aligned commas
//   ACTIVE | locked; data bytes delivered at each boundary
module serial_paralelo_rx
    import phy_rx_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] COMMA        = COMMA_SYMBOL,
    parameter int               LOCK_COUNT   = LOCK_COUNT_DEF
`ifdef SERIAL_PARALELO_RX_LOSS_EN
   ,parameter int               MAX_DATA_RUN = MAX_DATA_RUN_DEF
`endif
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             byte_strobe,
    output logic             active
);

    localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       comma_cnt_q, comma_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             strobe_q, strobe_d;
    logic [WIDTH-1:0] window;
    logic             is_comma;
    logic             boundary;

    deser_shift #(.WIDTH(WIDTH)) u_deser (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .serial_in(serial_in),
        .window_o (window)
    );

    assign is_comma = (window == COMMA);
    assign boundary = (bit_cnt_q == 3'd7);

`ifdef SERIAL_PARALELO_RX_LOSS_EN
    localparam logic [4:0] MAX_RUN5 = 5'(MAX_DATA_RUN);
    logic [4:0] run_q, run_d;

    always_ff @(posedge clk_8f) begin
        if (reset) run_q <= '0;
        else       run_q <= run_d;
    end
`endif

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
`ifdef SERIAL_PARALELO_RX_LOSS_EN
        run_d       = run_q;
`endif
        unique case (state_q)
            HUNT: begin
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = 4'd1;
                    state_d     = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + 4'd1;
                        if (comma_cnt_d == LOCK_CNT4) state_d = ACTIVE;
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = HUNT;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (is_comma) begin
                        valid_d = 1'b0;
`ifdef SERIAL_PARALELO_RX_LOSS_EN
                        run_d   = '0;
`endif
                    end else begin
                        data_d  = window;
                        valid_d = 1'b1;
`ifdef SERIAL_PARALELO_RX_LOSS_EN
                        run_d   = run_q + 5'd1;
                        // Too long without a comma: assume the link slipped and re-hunt.
                        if (run_d == MAX_RUN5) begin
                            data_d      = data_q;
                            valid_d     = 1'b0;
                            comma_cnt_d = '0;
                            run_d       = '0;
                            state_d     = HUNT;
                        end
`endif
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = (state_q == ACTIVE);

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed self-checking bench for serial_paralelo_rx (LOCK_COUNT=4, MSB-first stream).
module tb_serial_paralelo_rx;

    logic       clk_8f;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int checks = 0;
    int errors = 0;

    serial_paralelo_rx dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .byte_strobe(byte_strobe),
        .active     (active)
    );

    initial begin
        clk_8f = 1'b0;
        forever #5 clk_8f = ~clk_8f;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(i[0]);
            checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL t1_data cyc%0d got=%h exp=00", i, data_out); end
            checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL t1_valid cyc%0d got=%b exp=0", i, valid_out); end
            checks++; if (active !== 1'b0) begin errors++; $display("FAIL t1_active cyc%0d got=%b exp=0", i, active); end
            checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL t1_strobe cyc%0d got=%b exp=0", i, byte_strobe); end
        end
        reset = 1'b0;
    endtask

    task automatic test_aligned_lock();
        logic [7:0] bc;
        do_reset();
        repeat (3) send_byte(8'hBC);
        bc = 8'hBC;
        for (int i = 7; i >= 1; i--) send_bit(bc[i]);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL t2_active_bit31 got=%b exp=0", active); end
        send_bit(bc[0]);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL t2_active_bit32 got=%b exp=1", active); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL t2_valid_bit32 got=%b exp=0", valid_out); end
        send_byte(8'hA4);
        checks++; if (data_out !== 8'hA4) begin errors++; $display("FAIL t2_data_bit40 got=%h exp=a4", data_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL t2_valid_bit40 got=%b exp=1", valid_out); end
        checks++; if (byte_strobe !== 1'b1) begin errors++; $display("FAIL t2_strobe_bit40 got=%b exp=1", byte_strobe); end
        send_bit(1'b0);
        checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL t2_strobe_bit41 got=%b exp=0", byte_strobe); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL t2_valid_bit41 got=%b exp=1", valid_out); end
    endtask

    task automatic test_offset_lock();
        logic [7:0] ee;
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (4) send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL t3_active got=%b exp=1", active); end
        send_byte(8'hFF);
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL t3_data_ff got=%h exp=ff", data_out); end
        ee = 8'hEE;
        for (int i = 7; i >= 1; i--) send_bit(ee[i]);
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL t3_data_hold got=%h exp=ff", data_out); end
        checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL t3_strobe_mid got=%b exp=0", byte_strobe); end
        send_bit(ee[0]);
        checks++; if (data_out !== 8'hEE) begin errors++; $display("FAIL t3_data_ee got=%h exp=ee", data_out); end
        checks++; if (byte_strobe !== 1'b1) begin errors++; $display("FAIL t3_strobe_ee got=%b exp=1", byte_strobe); end
    endtask

    task automatic test_align_break();
        do_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h32);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL t4_active_after32 got=%b exp=0", active); end
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL t4_active_3commas got=%b exp=0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL t4_active_4commas got=%b exp=1", active); end
    endtask

    task automatic test_data_comma_mix();
        do_reset();
        repeat (4) send_byte(8'hBC);
        send_byte(8'hDD);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL t5_valid_dd got=%b exp=1", valid_out); end
        checks++; if (data_out !== 8'hDD) begin errors++; $display("FAIL t5_data_dd got=%h exp=dd", data_out); end
        send_byte(8'hBC);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL t5_valid_bc got=%b exp=0", valid_out); end
        checks++; if (data_out !== 8'hDD) begin errors++; $display("FAIL t5_data_bc got=%h exp=dd", data_out); end
        checks++; if (byte_strobe !== 1'b1) begin errors++; $display("FAIL t5_strobe_bc got=%b exp=1", byte_strobe); end
        send_byte(8'hCC);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL t5_valid_cc got=%b exp=1", valid_out); end
        checks++; if (data_out !== 8'hCC) begin errors++; $display("FAIL t5_data_cc got=%h exp=cc", data_out); end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b1;
        send_bit(1'b1);
        reset = 1'b0;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL t5_rst_data got=%h exp=00", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL t5_rst_valid got=%b exp=0", valid_out); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL t5_rst_active got=%b exp=0", active); end
        checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL t5_rst_strobe got=%b exp=0", byte_strobe); end
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL t5_relock_early got=%b exp=0", active); end
    endtask

    task automatic test_data_run();
        do_reset();
        repeat (4) send_byte(8'hBC);
        repeat (15) send_byte(8'h01);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL t6_active_15 got=%b exp=1", active); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL t6_valid_15 got=%b exp=1", valid_out); end
        send_byte(8'h01);
        checks++; if (byte_strobe !== 1'b1) begin errors++; $display("FAIL t6_strobe_16 got=%b exp=1", byte_strobe); end
`ifdef SERIAL_PARALELO_RX_LOSS_EN
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL t6_active_16 got=%b exp=0", active); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL t6_valid_16 got=%b exp=0", valid_out); end
`else
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL t6_active_16 got=%b exp=1", active); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL t6_valid_16 got=%b exp=1", valid_out); end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        serial_in = 1'b0;
        #1;
        test_reset();
        test_aligned_lock();
        test_offset_lock();
        test_align_break();
        test_data_comma_mix();
        test_data_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
